// File: rtl/axil_master_pkg.sv
// Shared types and constants for the AXI4-Lite configuration master.
package axil_master_pkg;

    localparam int unsigned CGRA_AXI_ADDR_WIDTH = 13;
    localparam int unsigned CGRA_AXI_DATA_WIDTH = 32;

    localparam logic [1:0] AXIL_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_EXOKAY = 2'b01;
    localparam logic [1:0] AXIL_SLVERR = 2'b10;
    localparam logic [1:0] AXIL_DECERR = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrRsp,
        StRdReq,
        StRdRsp,
        StRsp
    } axil_mst_state_e;

endpackage

// File: rtl/axil_timeout_cnt.sv
// Saturating phase watchdog; expired stays high once the limit is reached until cleared.
module axil_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CntMax);

endmodule

// File: rtl/axil_cfg_master.sv
// AXI4-Lite initiator: one register command in flight, response returned on a valid/ready channel.
module axil_cfg_master
    import axil_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = CGRA_AXI_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = CGRA_AXI_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_write,
    output logic                  timeout,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    axil_mst_state_e state_q, state_d;

    logic                  live_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q;
    logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            resp_q;
    logic                  aw_done, w_done;
    logic                  phase_busy;

    // live_q keeps cmd_ready low until the first edge after reset release.
    assign cmd_ready = (state_q == StIdle) && live_q;
    assign aw_done   = !awvalid_q || awready;
    assign w_done    = !wvalid_q || wready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_valid && cmd_ready) state_d = cmd_write ? StWrReq : StRdReq;
            StWrReq: if (aw_done && w_done) state_d = StWrRsp;
            StWrRsp: if (bvalid) state_d = StRsp;
            StRdReq: if (arready) state_d = StRdRsp;
            StRdRsp: if (rvalid) state_d = StRsp;
            StRsp:   if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            live_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        write_q   <= cmd_write;
                        awvalid_q <= cmd_write;
                        wvalid_q  <= cmd_write;
                        arvalid_q <= !cmd_write;
                    end
                end
                StWrReq: begin
                    if (awready) awvalid_q <= 1'b0;
                    if (wready) wvalid_q <= 1'b0;
                    if (aw_done && w_done) bready_q <= 1'b1;
                end
                StWrRsp: begin
                    if (bvalid) begin
                        bready_q    <= 1'b0;
                        resp_q      <= bresp;
                        rdata_q     <= '0;
                        rsp_valid_q <= 1'b1;
                    end
                end
                StRdReq: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                StRdRsp: begin
                    if (rvalid) begin
                        rready_q    <= 1'b0;
                        rdata_q     <= rdata;
                        resp_q      <= rresp;
                        rsp_valid_q <= 1'b1;
                    end
                end
                StRsp: begin
                    if (rsp_ready) rsp_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign phase_busy = (state_q == StWrReq) || (state_q == StWrRsp) ||
                        (state_q == StRdReq) || (state_q == StRdRsp);

    axil_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state_d != state_q),
        .en      (phase_busy),
        .expired (timeout)
    );

    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign wdata     = wdata_q;
    assign awvalid   = awvalid_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign rsp_write = write_q;

endmodule
